// File: rtl/ps2_pkg.sv
// Shared PS/2 receive definitions: FSM states, prefix bytes, key_status bit map.
// No logic, no latency; consumed by the keyboard receiver and its clock filter user.
package ps2_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RECV  = 2'd1,
    CHECK = 2'd2
  } ps2_state_e;

  localparam logic [7:0] PS2_BREAK = 8'hF0;
  localparam logic [7:0] PS2_EXT   = 8'hE0;

  localparam int KS_BREAK = 0;
  localparam int KS_NEW   = 1;
  localparam int KS_EXT   = 2;
  localparam int KS_ERR   = 3;

  localparam int FRAME_BITS = 11;

  // Frame shift register layout: [0] start, [8:1] data, [9] parity, [10] stop.
  function automatic logic frame_ok(input logic [10:0] f);
    return (~f[0]) & (^f[9:1]) & f[10];
  endfunction

endpackage

// File: rtl/ps2_clk_filter.sv
// Synchronises raw PS/2 clock/data and debounces the clock; fall_o pulses one cycle
// per filtered falling edge, 2 + FILTER_LEN cycles after the pin edge. No backpressure.
module ps2_clk_filter #(
  parameter int FILTER_LEN = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic ps2_clk_i,
  input  logic ps2_data_i,
  output logic fall_o,
  output logic data_o
);

  localparam int CW = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;

  logic          clk_s1_q, clk_s2_q, dat_s1_q, dat_s2_q;
  logic          filt_q, filt_d;
  logic          fall_q, fall_d;
  logic [CW-1:0] cnt_q, cnt_d;

  // Idle bus level is high, so everything resets to 1 to avoid a false fall.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      clk_s1_q <= 1'b1;
      clk_s2_q <= 1'b1;
      dat_s1_q <= 1'b1;
      dat_s2_q <= 1'b1;
      filt_q   <= 1'b1;
      fall_q   <= 1'b0;
      cnt_q    <= '0;
    end else begin
      clk_s1_q <= ps2_clk_i;
      clk_s2_q <= clk_s1_q;
      dat_s1_q <= ps2_data_i;
      dat_s2_q <= dat_s1_q;
      filt_q   <= filt_d;
      fall_q   <= fall_d;
      cnt_q    <= cnt_d;
    end
  end

  always_comb begin
    filt_d = filt_q;
    cnt_d  = '0;
    if (clk_s2_q != filt_q) begin
      if (cnt_q == CW'(FILTER_LEN - 1)) filt_d = clk_s2_q;
      else                              cnt_d  = cnt_q + 1'b1;
    end
    fall_d = filt_q & ~filt_d;
  end

  assign fall_o = fall_q;
  assign data_o = dat_s2_q;

endmodule

// File: rtl/ps2_keyboard_rx.sv
// PS/2 keyboard receiver: strips F0/E0 prefixes, publishes keycode with a 1-cycle strobe
// two cycles after the 11th filtered fall. No backpressure: an unsampled code is lost.
module ps2_keyboard_rx
  import ps2_pkg::*;
#(
  parameter int FILTER_LEN     = 4,
  parameter int TIMEOUT_CYCLES = 10000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic [7:0] keycode,
  output logic [7:0] key_status
);

  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  logic          fall, sdata, timeout;
  ps2_state_e    state_q, state_d;
  logic [3:0]    bit_cnt_q, bit_cnt_d;
  logic [10:0]   shift_q, shift_d;
  logic [TW-1:0] to_cnt_q, to_cnt_d;
  logic [7:0]    kc_q, kc_d;
  logic          brk_q, brk_d, ext_q, ext_d, new_q, new_d, err_q, err_d;
  logic          brk_pend_q, brk_pend_d, ext_pend_q, ext_pend_d;

  ps2_clk_filter #(.FILTER_LEN(FILTER_LEN)) u_filter (
    .clk        (clk),
    .rst_n      (rst_n),
    .ps2_clk_i  (ps2_clk),
    .ps2_data_i (ps2_data),
    .fall_o     (fall),
    .data_o     (sdata)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      bit_cnt_q  <= '0;
      shift_q    <= '0;
      to_cnt_q   <= '0;
      kc_q       <= '0;
      brk_q      <= 1'b0;
      ext_q      <= 1'b0;
      new_q      <= 1'b0;
      err_q      <= 1'b0;
      brk_pend_q <= 1'b0;
      ext_pend_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      bit_cnt_q  <= bit_cnt_d;
      shift_q    <= shift_d;
      to_cnt_q   <= to_cnt_d;
      kc_q       <= kc_d;
      brk_q      <= brk_d;
      ext_q      <= ext_d;
      new_q      <= new_d;
      err_q      <= err_d;
      brk_pend_q <= brk_pend_d;
      ext_pend_q <= ext_pend_d;
    end
  end

  // Bits shift in from the top so the start bit lands at [0] after 11 falls.
  always_comb begin
    state_d   = state_q;
    bit_cnt_d = bit_cnt_q;
    shift_d   = shift_q;
    to_cnt_d  = '0;
    timeout   = 1'b0;
    case (state_q)
      IDLE: begin
        if (fall && !sdata) begin
          state_d   = RECV;
          bit_cnt_d = 4'd1;
          shift_d   = {sdata, shift_q[10:1]};
        end
      end
      RECV: begin
        if (fall) begin
          shift_d   = {sdata, shift_q[10:1]};
          bit_cnt_d = bit_cnt_q + 4'd1;
          if (bit_cnt_q == 4'(FRAME_BITS - 1)) state_d = CHECK;
        end else if (to_cnt_q == TW'(TIMEOUT_CYCLES - 1)) begin
          timeout   = 1'b1;
          state_d   = IDLE;
          bit_cnt_d = '0;
        end else begin
          to_cnt_d = to_cnt_q + 1'b1;
        end
      end
      CHECK: begin
        state_d   = IDLE;
        bit_cnt_d = '0;
      end
      default: begin
        state_d   = IDLE;
        bit_cnt_d = '0;
      end
    endcase
  end

  always_comb begin
    kc_d       = kc_q;
    brk_d      = brk_q;
    ext_d      = ext_q;
    new_d      = 1'b0;
    err_d      = 1'b0;
    brk_pend_d = brk_pend_q;
    ext_pend_d = ext_pend_q;
    if (timeout || (state_q == CHECK && !frame_ok(shift_q))) begin
      err_d      = 1'b1;
      brk_pend_d = 1'b0;
      ext_pend_d = 1'b0;
    end else if (state_q == CHECK) begin
      if (shift_q[8:1] == PS2_BREAK) begin
        brk_pend_d = 1'b1;
      end else if (shift_q[8:1] == PS2_EXT) begin
        ext_pend_d = 1'b1;
      end else begin
        kc_d       = shift_q[8:1];
        brk_d      = brk_pend_q;
        ext_d      = ext_pend_q;
        new_d      = 1'b1;
        brk_pend_d = 1'b0;
        ext_pend_d = 1'b0;
      end
    end
  end

  always_comb begin
    key_status           = '0;
    key_status[KS_BREAK] = brk_q;
    key_status[KS_NEW]   = new_q;
    key_status[KS_EXT]   = ext_q;
    key_status[KS_ERR]   = err_q;
  end

  assign keycode = kc_q;

endmodule
